// File: rtl/mixed_reduce_pkg.sv
// Shared types and helpers for the mixed_reduce_pipe datapath.
// Optional statistics counter is enabled by defining MIXED_REDUCE_PIPE_STATS_EN.
package mixed_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIMED = 2'd1,
    RUN    = 2'd2
  } lane_state_e;

  localparam int STAT_W  = 16;
  localparam int MAX_NCH = 16;

  function automatic logic [STAT_W-1:0] popcount(input logic [MAX_NCH-1:0] v);
    logic [STAT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_NCH; i++) n = n + STAT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mrp_lane.sv
// One channel of mixed_reduce_pipe: capture, sign gate, hold update FSM and NOR flag.
//   state  | meaning
//   IDLE   | no gated beat since reset/clear; next gated beat loads LOAD_VAL
//   PRIMED | LOAD_VAL loaded; next gated beat XNOR-mixes
//   RUN    | at least one mix applied; gated beats keep XNOR-mixing
module mrp_lane
  import mixed_reduce_pkg::*;
#(
  parameter int              DW       = 8,
  parameter logic [DW-1:0]   LOAD_VAL = 8'hB0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_accept,
  input  logic          i_adv,
  input  logic          i_upd,
  input  logic          i_clr,
  input  logic [DW-1:0] i_data,
  output logic          o_gate,
  output logic [DW-1:0] o_hold,
  output logic          o_flag
);

  logic [DW-1:0] r_s1;
  logic [DW-1:0] r_s2;
  logic          r_g;
  lane_state_e   r_state;
  lane_state_e   w_state_nxt;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] w_hold_nxt;
  logic          r_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_g  <= 1'b0;
    end else begin
      if (i_accept) r_s1 <= i_data;
      if (i_adv) begin
        r_s2 <= r_s1;
        r_g  <= ~r_s1[DW-1];
      end
    end
  end

  // Clear outranks any update landing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (i_clr) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
    end else if (i_upd && r_g) begin
      case (r_state)
        IDLE: begin
          w_hold_nxt  = LOAD_VAL;
          w_state_nxt = PRIMED;
        end
        PRIMED: begin
          w_hold_nxt  = ~(r_s2 ^ r_hold);
          w_state_nxt = RUN;
        end
        RUN: begin
          w_hold_nxt  = ~(r_s2 ^ r_hold);
          w_state_nxt = RUN;
        end
        default: begin
          w_hold_nxt  = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_flag  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_flag  <= ~|w_hold_nxt[DW-1:DW/2];
    end
  end

  assign o_gate = r_g;
  assign o_hold = r_hold;
  assign o_flag = r_flag;

endmodule

// File: rtl/mixed_reduce_pipe.sv
// Multi-channel 3-stage sign-gate / XNOR-reduce pipeline behind valid/ready.
// Define MIXED_REDUCE_PIPE_STATS_EN to build the saturating gated-beat counter.
module mixed_reduce_pipe
  import mixed_reduce_pkg::*;
#(
  parameter int            DW       = 8,
  parameter int            NCH      = 4,
  parameter logic [DW-1:0] LOAD_VAL = 8'hB0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*DW-1:0] out_y,
  output logic [NCH-1:0]    out_flag,
  output logic [STAT_W-1:0] stat_cnt
);

  logic           r_v1, r_v2, r_v3;
  logic           r_clear_pend;
  logic           w_adv;
  logic           w_accept;
  logic           w_upd;
  logic           w_clr_apply;
  logic [NCH-1:0] w_gate;

  assign w_adv       = ~r_v3 | out_ready;
  assign w_accept    = in_valid & w_adv;
  assign w_upd       = w_adv & r_v2;
  assign w_clr_apply = w_adv & (r_clear_pend | clear);
  assign in_ready    = w_adv;
  assign out_valid   = r_v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // A clear seen during a stall waits here for the next advancing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_clear_pend <= 1'b0;
    else if (w_clr_apply) r_clear_pend <= 1'b0;
    else if (clear)       r_clear_pend <= 1'b1;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    mrp_lane #(
      .DW       (DW),
      .LOAD_VAL (LOAD_VAL)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_accept (w_accept),
      .i_adv    (w_adv),
      .i_upd    (w_upd),
      .i_clr    (w_clr_apply),
      .i_data   (in_data[c*DW +: DW]),
      .o_gate   (w_gate[c]),
      .o_hold   (out_y[c*DW +: DW]),
      .o_flag   (out_flag[c])
    );
  end

`ifdef MIXED_REDUCE_PIPE_STATS_EN
  logic [MAX_NCH-1:0] w_gate_ext;
  logic [STAT_W:0]    w_sum;
  logic [STAT_W-1:0]  r_stat;

  always_comb begin
    w_gate_ext             = '0;
    w_gate_ext[NCH-1:0]    = w_gate;
    w_sum                  = {1'b0, r_stat} + {1'b0, popcount(w_gate_ext)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_stat <= '0;
    else if (w_clr_apply) r_stat <= '0;
    else if (w_upd)       r_stat <= w_sum[STAT_W] ? '1 : w_sum[STAT_W-1:0];
  end

  assign stat_cnt = r_stat;
`else
  logic w_unused_gate;
  assign w_unused_gate = ^w_gate;
  assign stat_cnt      = '0;
`endif

endmodule

// File: tb/tb_mixed_reduce_pipe.sv
// Scoreboard bench for mixed_reduce_pipe (DW=8, NCH=4) against a per-beat reference model.
module tb_mixed_reduce_pipe;

  localparam int          DW    = 8;
  localparam int          NCH   = 4;
  localparam logic [7:0]  LOADV = 8'hB0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*DW-1:0] out_y;
  logic [NCH-1:0]    out_flag;
  logic [15:0]       stat_cnt;

  always #5 clk = ~clk;

  mixed_reduce_pipe #(.DW(DW), .NCH(NCH), .LOAD_VAL(LOADV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_flag  (out_flag),
    .stat_cnt  (stat_cnt)
  );

  typedef struct {
    logic [31:0] y;
    logic [3:0]  flag;
    logic [15:0] stat;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  m_hold[NCH];
  bit          m_seen[NCH];
  int unsigned m_stat;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_hold[c] = 8'h00;
      m_seen[c] = 1'b0;
    end
    m_stat = 0;
  endfunction

  // Each accepted beat, in order: clear beats wipe everything, otherwise
  // non-negative lanes load LOADV the first time and XNOR-mix afterwards.
  function automatic exp_t model_beat(input logic [31:0] d, input bit clr);
    exp_t       e;
    int         gcount;
    logic [7:0] lane;
    if (clr) begin
      model_reset();
    end else begin
      gcount = 0;
      for (int c = 0; c < NCH; c++) begin
        lane = d[c*8 +: 8];
        if (lane[7] == 1'b0) begin
          gcount++;
          if (!m_seen[c]) begin
            m_hold[c] = LOADV;
            m_seen[c] = 1'b1;
          end else begin
            m_hold[c] = ~(lane ^ m_hold[c]);
          end
        end
      end
      m_stat = m_stat + gcount;
      if (m_stat > 65535) m_stat = 65535;
    end
    for (int c = 0; c < NCH; c++) begin
      e.y[c*8 +: 8] = m_hold[c];
      e.flag[c]     = (m_hold[c] < 8'h10);
    end
`ifdef MIXED_REDUCE_PIPE_STATS_EN
    e.stat = m_stat[15:0];
`else
    e.stat = 16'h0000;
`endif
    return e;
  endfunction

  // Monitor: every presented output is compared with the oldest expectation;
  // it is retired only when the consumer takes it, so stalls re-check it.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got out_y=%0h with no beat outstanding", out_y);
      end else begin
        chk("out_y", out_y, sb_q[0].y);
        chk("out_flag", out_flag, sb_q[0].flag);
        chk("stat_cnt", stat_cnt, sb_q[0].stat);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input bit vld, input logic [31:0] d, input bit ordy,
                      input bit clr, input bit clr_beat);
    @(negedge clk);
    in_valid  = vld;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    if (vld && in_ready) sb_q.push_back(model_beat(d, clr_beat));
  endtask

  // d0 is the beat moving S2->S3 while clear is high, two cycles after its accept.
  task automatic clear_triple(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    step(1'b1, d0, 1'b1, 1'b0, 1'b1);
    step(1'b1, d1, 1'b1, 1'b0, 1'b0);
    step(1'b1, d2, 1'b1, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] all_gated(input logic [31:0] r);
    return r & 32'h7F7F7F7F;
  endfunction

  initial begin
    int drain;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_flag", out_flag, 4'hF);
    chk("rst_stat", stat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First gated beat loads, then mix, then a negative beat leaves hold alone.
    step(1'b1, 32'h80808010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h8080800F, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h80808085, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      step(($urandom_range(3, 0) != 0), $urandom, ($urandom_range(9, 0) < 7), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    clear_triple(32'h80808022, 32'h80808001, 32'h8080800F);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      clear_triple($urandom, $urandom, $urandom);
      for (int j = 0; j < 5; j++)
        step(($urandom_range(1, 0) == 1), $urandom, ($urandom_range(1, 0) == 1), 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset with all three stages full: in-flight beats must vanish.
    for (int i = 0; i < 3; i++) step(1'b1, all_gated($urandom), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_y", out_y, 0);
    chk("midrst_out_flag", out_flag, 4'hF);
    chk("midrst_stat", stat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h01808001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h7F00FF33, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef MIXED_REDUCE_PIPE_STATS_EN
    for (int i = 0; i < 16400; i++) step(1'b1, all_gated($urandom), 1'b1, 1'b0, 1'b0);
`endif

    drain = 0;
    while (sb_q.size() != 0 && drain < 20) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      drain++;
    end
    #3;
    chk("drain_outstanding", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
